// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, field positions and instruction classifier for cpu_ctrl
//   Holds FSM state codes, opcode/op values, instruction field offsets and
//   a classify() helper that maps {opcode, op} to an instruction kind.
package cpu_pkg;

  // FSM state codes
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_GET_A     = 3'd2;
  localparam logic [2:0] S_GET_B     = 3'd3;
  localparam logic [2:0] S_EXEC      = 3'd4;
  localparam logic [2:0] S_WRITE_REG = 3'd5;
  localparam logic [2:0] S_WRITE_IMM = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  // opcode field values
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field values
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  // instruction field LSB positions
  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  typedef enum logic [2:0] {
    K_UNDEF, K_MOV_IMM, K_MOV_REG, K_MVN, K_ADD, K_CMP, K_AND, K_HALT
  } instr_kind_e;

  // 110/01 and 110/11 are not defined and fall into K_UNDEF with every
  // opcode other than 101, 110 and 111.
  function automatic instr_kind_e classify(input logic [2:0] opcode, input logic [1:0] op);
    instr_kind_e k;
    k = K_UNDEF;
    if (opcode == OPC_HALT) begin
      k = K_HALT;
    end else if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      k = K_MOV_IMM;
      else if (op == OP_MOV_REG) k = K_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  k = K_ADD;
        OP_CMP:  k = K_CMP;
        OP_AND:  k = K_AND;
        default: k = K_MVN;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - instruction handshake and datapath control bundle for cpu_ctrl
//   master: instruction source / datapath side (drives in_instr, in_valid)
//   slave : cpu_ctrl (drives in_ready, register indices, selects, enables,
//           immediates, done, halted)
interface cpu_ctrl_if;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic        asel;
  logic [1:0]  bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        done;
  logic        halted;

  modport master (
    output in_instr, in_valid,
    input  in_ready, readnum, writenum, vsel, loada, loadb, loadc, loads,
           write, asel, bsel, shift, ALUop, sximm8, sximm5, done, halted
  );

  modport slave (
    input  in_instr, in_valid,
    output in_ready, readnum, writenum, vsel, loada, loadb, loadc, loads,
           write, asel, bsel, shift, ALUop, sximm8, sximm5, done, halted
  );
endinterface

// File: rtl/instr_dec.sv
// rtl/instr_dec.sv - combinational field extraction and immediate sign extension
//   in : ir[15:0]
//   out: opcode, op, rn, rd, shift, rm, sximm8, sximm5
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  shift,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);
  assign opcode = ir[OPC_LSB +: 3];
  assign op     = ir[OP_LSB +: 2];
  assign rn     = ir[RN_LSB +: 3];
  assign rd     = ir[RD_LSB +: 3];
  assign shift  = ir[SH_LSB +: 2];
  assign rm     = ir[RM_LSB +: 3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle instruction controller FSM
//   clk     : sole clock
//   reset_n : asynchronous active-low reset
//   bus     : cpu_ctrl_if.slave (instruction handshake in, datapath controls out)
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  cpu_ctrl_if.slave  bus
);
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] ir;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [1:0]  ir_shift;
  logic [2:0]  rm;
  logic [15:0] imm8_sx;
  logic [15:0] imm5_sx;
  instr_kind_e kind;

  instr_dec u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .shift  (ir_shift),
    .rm     (rm),
    .sximm8 (imm8_sx),
    .sximm5 (imm5_sx)
  );

  assign kind       = classify(opcode, op);
  assign bus.sximm8 = imm8_sx;
  assign bus.sximm5 = imm5_sx;

  // IR only loads on an accept, so in_instr is ignored outside IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus.in_valid) ir <= bus.in_instr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.in_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        case (kind)
          K_MOV_IMM:           state_nxt = S_WRITE_IMM;
          K_MOV_REG, K_MVN:    state_nxt = S_GET_B;
          K_ADD, K_CMP, K_AND: state_nxt = S_GET_A;
          K_HALT:              state_nxt = S_HALT;
          default:             state_nxt = S_IDLE;
        endcase
      end
      S_GET_A:     state_nxt = S_GET_B;
      S_GET_B:     state_nxt = S_EXEC;
      S_EXEC:      state_nxt = (kind == K_CMP) ? S_IDLE : S_WRITE_REG;
      S_WRITE_REG: state_nxt = S_IDLE;
      S_WRITE_IMM: state_nxt = S_IDLE;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: every enable/select is 0 unless the current state names it.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.vsel     = 2'b00;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.write    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 2'b00;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;
    bus.done     = 1'b0;
    bus.halted   = 1'b0;
    case (state)
      S_IDLE:   bus.in_ready = 1'b1;
      S_DECODE: bus.done = (kind == K_UNDEF);
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      S_EXEC: begin
        bus.shift = ir_shift;
        bus.bsel  = 2'b00;
        // MOV reg and MVN pass B through against a zero A operand.
        if (kind == K_MOV_REG) begin
          bus.asel  = 1'b1;
          bus.ALUop = 2'b00;
        end else if (kind == K_MVN) begin
          bus.asel  = 1'b1;
          bus.ALUop = 2'b11;
        end else begin
          bus.asel  = 1'b0;
          bus.ALUop = op;
        end
        if (kind == K_CMP) begin
          bus.loads = 1'b1;
          bus.done  = 1'b1;
        end else begin
          bus.loadc = 1'b1;
        end
      end
      S_WRITE_REG: begin
        bus.vsel     = 2'b00;
        bus.writenum = rd;
        bus.write    = 1'b1;
        bus.done     = 1'b1;
      end
      S_WRITE_IMM: begin
        bus.vsel     = 2'b10;
        bus.writenum = rn;
        bus.write    = 1'b1;
        bus.done     = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - self-checking bench for cpu_ctrl against an instruction-level model
module tb_cpu_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [8:0] pad;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic [1:0] bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic       done;
    logic       in_ready;
    logic       halted;
  } ctl_t;

  int   total = 0;
  int   bad = 0;
  ctl_t exp_q[$];
  int   exp_lat;
  ctl_t idle_c;
  ctl_t halt_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t c;
    c = '0;
    c.readnum  = bus.readnum;
    c.writenum = bus.writenum;
    c.vsel     = bus.vsel;
    c.loada    = bus.loada;
    c.loadb    = bus.loadb;
    c.loadc    = bus.loadc;
    c.loads    = bus.loads;
    c.write    = bus.write;
    c.asel     = bus.asel;
    c.bsel     = bus.bsel;
    c.shift    = bus.shift;
    c.aluop    = bus.ALUop;
    c.done     = bus.done;
    c.in_ready = bus.in_ready;
    c.halted   = bus.halted;
    return c;
  endfunction

  // Two's-complement sign extension of a 'bits'-wide field to 16 bits.
  function automatic logic [31:0] sx(input int v, input int bits);
    int s;
    s = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    return 32'(s & 16'hFFFF);
  endfunction

  // Builds the per-cycle expectation (cycle 1 = first cycle after accept)
  // from the instruction's meaning.
  task automatic expect_seq(input logic [15:0] instr);
    int opc, op, rn, rd, sh, rm;
    ctl_t c;
    opc = (int'(instr) >> 13) & 7;
    op  = (int'(instr) >> 11) & 3;
    rn  = (int'(instr) >> 8) & 7;
    rd  = (int'(instr) >> 5) & 7;
    sh  = (int'(instr) >> 3) & 3;
    rm  = int'(instr) & 7;
    exp_q.delete();
    c = '0;
    if (opc == 6 && op == 2) begin
      exp_q.push_back(c);
      c.vsel = 2'b10; c.writenum = 3'(rn); c.write = 1'b1; c.done = 1'b1;
      exp_q.push_back(c);
      exp_lat = 2;
    end else if ((opc == 6 && op == 0) || opc == 5) begin
      exp_q.push_back(c);
      if (opc == 5 && op != 3) begin
        c = '0; c.readnum = 3'(rn); c.loada = 1'b1;
        exp_q.push_back(c);
      end
      c = '0; c.readnum = 3'(rm); c.loadb = 1'b1;
      exp_q.push_back(c);
      c = '0; c.shift = 2'(sh);
      if (opc == 6)      begin c.asel = 1'b1; c.aluop = 2'b00; end
      else if (op == 3)  begin c.asel = 1'b1; c.aluop = 2'b11; end
      else               c.aluop = 2'(op);
      if (opc == 5 && op == 1) begin
        c.loads = 1'b1; c.done = 1'b1;
        exp_q.push_back(c);
        exp_lat = 4;
      end else begin
        c.loadc = 1'b1;
        exp_q.push_back(c);
        c = '0; c.writenum = 3'(rd); c.write = 1'b1; c.done = 1'b1;
        exp_q.push_back(c);
        exp_lat = (opc == 5) ? ((op == 3) ? 4 : 5) : 4;
      end
    end else begin
      c.done = 1'b1;
      exp_q.push_back(c);
      exp_lat = 1;
    end
  endtask

  // Issues one instruction from IDLE and checks every cycle through done;
  // in_valid/in_instr are scrambled while busy to show they are ignored.
  task automatic run_instr(input logic [15:0] instr, input string tag, input int stop_at);
    int lat;
    int n;
    expect_seq(instr);
    @(negedge clk);
    check({tag, " idle"}, observe(), idle_c);
    bus.in_instr = instr;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'($urandom);
    bus.in_instr = 16'($urandom);
    lat = 0;
    n = (stop_at > 0) ? stop_at : exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", tag, k + 1), observe(), exp_q[k]);
      check($sformatf("%s sximm8", tag), 32'(bus.sximm8), sx(int'(instr) & 255, 8));
      check($sformatf("%s sximm5", tag), 32'(bus.sximm5), sx(int'(instr) & 31, 5));
      if (bus.done && lat == 0) lat = k + 1;
      bus.in_instr = 16'($urandom);
      bus.in_valid = (k == n - 1) ? 1'b0 : 1'($urandom);
    end
    if (stop_at == 0) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  function automatic logic [15:0] rand_instr();
    logic [2:0] opc;
    logic [1:0] op;
    case ($urandom_range(0, 6))
      0: begin opc = 3'b110; op = 2'b10; end
      1: begin opc = 3'b110; op = 2'b00; end
      2: begin opc = 3'b101; op = 2'b11; end
      3: begin opc = 3'b101; op = 2'b00; end
      4: begin opc = 3'b101; op = 2'b01; end
      5: begin opc = 3'b101; op = 2'b10; end
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          opc = 3'($urandom_range(0, 4)); op = 2'($urandom);
        end else begin
          opc = 3'b110; op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
        end
      end
    endcase
    return {opc, op, 11'($urandom)};
  endfunction

  initial begin
    idle_c = '0;
    idle_c.in_ready = 1'b1;
    halt_c = '0;
    halt_c.halted = 1'b1;
    bus.in_instr = 16'h0000;
    bus.in_valid = 1'b0;

    #12;
    check("reset outputs", observe(), idle_c);
    check("reset sximm8", 32'(bus.sximm8), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run_instr(16'hD0FD, "mov_imm", 0);
    run_instr(16'hA148, "add", 0);
    run_instr(16'hA900, "cmp", 0);
    run_instr(16'h0000, "undef", 0);

    // Reset during GET_B of ADD: everything drops at once, no write happens.
    run_instr(16'hA148, "add_abort", 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort outputs", observe(), idle_c);
    check("abort sximm8", 32'(bus.sximm8), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_instr(16'hD0FD, "mov_after_abort", 0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ins;
      ins = rand_instr();
      run_instr(ins, $sformatf("rnd%0d_%04h", i, ins), 0);
    end

    // HALT with in_valid held high stays halted until reset.
    @(negedge clk);
    check("halt idle", observe(), idle_c);
    bus.in_instr = 16'hE000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_instr = 16'($urandom);
    @(negedge clk);
    check("halt decode", observe(), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("halted c%0d", k), observe(), halt_c);
      bus.in_instr = 16'($urandom);
    end
    #2;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("halt reset", observe(), idle_c);
    @(negedge clk);
    reset_n = 1'b1;
    run_instr(16'hA900, "cmp_after_halt", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 cpu_ctrl SHALL have one clock and an asynchronous, active-low reset; all state changes on posedge clk.
REQ-002 clk  in  1  sole clock.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 in_instr  in  16  instruction word; [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8, [4:0] imm5.
REQ-005 in_valid  in  1  in_instr is valid this cycle.
REQ-006 in_ready  out  1  controller can accept an instruction.
REQ-007 readnum, writenum  out  3 each  register file read and write indices.
REQ-008 vsel  out  2  writeback select: 00 ALU result, 10 sximm8; 01 and 11 are never driven.
REQ-009 loada, loadb, loadc, loads, write  out  1 each  datapath load and write enables.
REQ-010 asel  out  1  1 selects a zero A operand.
REQ-011 bsel  out  2  00 shifted B, 01 sximm5; 10 is never driven.
REQ-012 shift, ALUop  out  2 each  shifter and ALU controls.
REQ-013 sximm8, sximm5  out  16 each  sign-extended immediates.
REQ-014 done  out  1  one-cycle pulse when the instruction completes.
REQ-015 halted  out  1  HALT executed; stays high until reset.

Function
REQ-016 The instruction SHALL be accepted when in_valid and in_ready are both high at a clock edge; it is latched into internal register IR.
REQ-017 States SHALL be IDLE, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM, HALT.
REQ-018 in_ready SHALL be 1 only in IDLE; acceptance moves IDLE to DECODE; in_instr is ignored in every other state.
REQ-019 DECODE transitions SHALL be:
- 110/10 MOV imm: to WRITE_IMM
- 110/00 MOV reg: to GET_B
- 101/11 MVN: to GET_B
- 101/00 ADD, 101/01 CMP, 101/10 AND: to GET_A
- 111 HALT: to HALT
- any other opcode: to IDLE, with done asserted in DECODE
REQ-020 GET_A SHALL drive readnum=Rn and loada=1, then go to GET_B.
REQ-021 GET_B SHALL drive readnum=Rm and loadb=1, then go to EXEC.
REQ-022 EXEC SHALL drive shift=IR shift and bsel=00.
- MOV reg: asel=1, ALUop=00.
- MVN: asel=1, ALUop=11.
- Otherwise: asel=0, ALUop=IR op.
REQ-023 In EXEC, loadc SHALL be 1 for every instruction except CMP, which instead drives loads=1, loadc=0, asserts done and goes to IDLE.
REQ-024 Non-CMP instructions SHALL go from EXEC to WRITE_REG, which drives vsel=00, writenum=Rd, write=1 and done=1, then goes to IDLE.
REQ-025 WRITE_IMM SHALL drive vsel=10, writenum=Rn, write=1 and done=1, then go to IDLE.
REQ-026 HALT SHALL assert halted and in_ready=0 and SHALL be left only by reset.
REQ-027 Outputs SHALL be Moore functions of state and IR; any enable not named for a state is 0.
REQ-028 Default output values SHALL be vsel=00, asel=0, bsel=00, shift=00, ALUop=00.
REQ-029 sximm8 SHALL equal {8{IR[7]}, IR[7:0]} and sximm5 SHALL equal {11{IR[4]}, IR[4:0]}, continuously.
REQ-030 Latency from the accept edge to the done cycle SHALL be:
- MOV imm: 2 cycles
- MOV reg, MVN: 4 cycles
- CMP: 4 cycles
- ADD, AND: 5 cycles
- undefined opcode: 1 cycle
REQ-031 The next instruction SHALL be accepted no earlier than the edge ending the done cycle, plus 1 cycle in IDLE.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, IR=0, halted=0 and all enables and selects to 0, including mid-instruction; no write is completed.
REQ-033 After reset_n deasserts, in_ready SHALL be 1 on the first clock.

Structure
REQ-034 State enum, opcode/op constants and field bit positions SHALL live in package cpu_pkg.
REQ-035 Field extraction and sign extension SHALL be one combinational sub-module, instr_dec.

Verification
REQ-036 MOV R0,#-3 (0xD0FD) -> WRITE_IMM on 2nd cycle after accept: writenum=0, vsel=10, sximm8=0xFFFD, write=1, done=1.
REQ-037 ADD R2,R1,R0 LSL#1 (0xA148) -> the following sequence, with done only in cycle 5:
- GET_A: readnum=1, loada=1.
- GET_B: readnum=0, loadb=1.
- EXEC: shift=01, asel=0, ALUop=00, loadc=1.
- WRITE_REG: writenum=2, write=1.
REQ-038 CMP R1,R0 (0xA900) -> EXEC drives ALUop=01, loads=1, loadc=0, done=1; write never asserted.
REQ-039 HALT (0xE000) then in_valid held high -> halted=1 and in_ready=0 indefinitely; after reset_n pulse, in_ready=1 and halted=0.
REQ-040 reset_n low during GET_B of 0xA148 -> all enables 0 at once; next accepted 0xD0FD completes normally.
REQ-041 Undefined 0x0000 -> done=1 in DECODE, no enables asserted, IDLE the next cycle.
